byte_word_packer: RTL and testbench



---
 rtl/cdc_pkg.sv | 22 ++
 rtl/word_out_reg.sv | 49 ++++
 rtl/byte_word_packer.sv | 147 ++++++++++++++
 tb/tb_byte_word_packer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC FIFO byte packer/unpacker pair.
// Contents:
//   DEFAULT_FIFO_WIDTH - default width of one FIFO entry (one lane)
//   DEFAULT_LANES      - default number of lanes per packed word
//   MAX_LANES          - largest supported lane count
//   mask_for_count(n)  - mask with the n low bits set
package cdc_pkg;

  localparam int unsigned DEFAULT_FIFO_WIDTH = 8;
  localparam int unsigned DEFAULT_LANES      = 4;
  localparam int unsigned MAX_LANES          = 16;

  function automatic logic [MAX_LANES-1:0] mask_for_count(input int unsigned n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/word_out_reg.sv
// One-entry ready/valid holding register for a data word plus lane mask.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_load        - write i_data/i_mask this cycle (caller loads only when o_free)
//   i_data/i_mask - word and lane mask to load
//   i_take        - downstream accepts the held word this cycle
//   o_ready       - register holds a word
//   o_data/o_mask - held word and mask, stable while o_ready && !i_take
//   o_free        - register is empty or draining this cycle
module word_out_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned MW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic [MW-1:0] i_mask,
  input  logic          i_take,
  output logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [MW-1:0] o_mask,
  output logic          o_free
);

  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [MW-1:0] r_mask;

  assign o_free  = !r_ready || i_take;
  assign o_ready = r_ready;
  assign o_data  = r_data;
  assign o_mask  = r_mask;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready <= 1'b0;
      r_data  <= '0;
      r_mask  <= '0;
    end else if (i_load) begin
      r_ready <= 1'b1;
      r_data  <= i_data;
      r_mask  <= i_mask;
    end else if (i_take) begin
      r_ready <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Read-side consumer of the CDC FIFO: packs LANES consecutive bytes into one
// little-endian word (lane 0 in the low bits) and holds it for downstream.
// A flush request emits the partially assembled word with a lane mask.
// Ports:
//   rdclk, rst    - FIFO read clock, synchronous active-high reset
//   fifoReady     - FIFO presents a byte on fifoData
//   fifoValid     - packer takes fifoData this cycle
//   fifoData      - FIFO head byte
//   flush         - single-cycle request to emit the partial word
//   wordReady     - output register holds a word
//   wordValid     - downstream accepts the word this cycle
//   wordData      - packed word
//   wordMask      - per-lane valid bits
//   flushPending  - flush latched but not yet emitted
module byte_word_packer
  import cdc_pkg::*;
#(
  parameter int unsigned IN_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int unsigned LANES    = DEFAULT_LANES,
  parameter int unsigned CNT_MSB  = $clog2(LANES) - 1
) (
  input  logic                      rdclk,
  input  logic                      rst,
  input  logic                      fifoReady,
  output logic                      fifoValid,
  input  logic [IN_WIDTH-1:0]       fifoData,
  input  logic                      flush,
  output logic                      wordReady,
  input  logic                      wordValid,
  output logic [IN_WIDTH*LANES-1:0] wordData,
  output logic [LANES-1:0]          wordMask,
  output logic                      flushPending
);

  localparam int unsigned AW = (LANES - 1) * IN_WIDTH;
  localparam int unsigned CW = CNT_MSB + 1;
  localparam logic [CNT_MSB:0] LAST_LANE = CW'(LANES - 1);

  logic [AW-1:0]    r_asm;
  logic [CNT_MSB:0] r_cnt;
  logic [LANES-2:0] r_asmMask;
  logic             r_flushPending;

  logic                      w_out_free;
  logic                      w_full;
  logic                      w_take;
  logic                      w_emit_full;
  logic                      w_emit_part;
  logic                      w_load;
  logic [CNT_MSB:0]          w_cnt_next;
  logic [AW-1:0]             w_asm_keep;
  logic [IN_WIDTH*LANES-1:0] w_load_data;
  logic [LANES-1:0]          w_load_mask;

  assign w_full    = (r_cnt == LAST_LANE);
  assign fifoValid = !rst
                   && !(w_full && !w_out_free)
                   && !(r_flushPending && (r_cnt != '0) && !w_out_free);
  assign w_take    = fifoReady && fifoValid;

  // A pending partial emit wins over a completing byte: when a flush left
  // cnt at LANES-1, the partial word goes out and the new byte starts lane 0.
  assign w_emit_part = r_flushPending && (r_cnt != '0) && w_out_free;
  assign w_emit_full = w_take && w_full && !w_emit_part;
  assign w_load      = w_emit_part || w_emit_full;

  // Lanes above cnt still hold bytes of an earlier word; blank them for partials.
  always_comb begin
    w_asm_keep = '0;
    for (int unsigned l = 0; l < LANES - 1; l++) begin
      w_asm_keep[l*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{r_asmMask[l]}};
    end
  end

  always_comb begin
    w_load_data = {fifoData, r_asm};
    w_load_mask = '1;
    if (w_emit_part) begin
      w_load_data = {{IN_WIDTH{1'b0}}, r_asm & w_asm_keep};
      w_load_mask = {1'b0, r_asmMask};
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_emit_part) begin
      w_cnt_next = w_take ? CW'(1) : '0;
    end else if (w_take) begin
      w_cnt_next = w_full ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge rdclk) begin
    if (rst) begin
      r_asm          <= '0;
      r_cnt          <= '0;
      r_asmMask      <= '0;
      r_flushPending <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      // A flush seen after this cycle's byte is counted; with nothing left
      // assembled (including a completed word) it has no effect.
      r_flushPending <= (w_cnt_next != '0)
                     && (flush || (r_flushPending && !w_emit_part));
      if (w_emit_part) begin
        r_asmMask <= '0;
        if (w_take) begin
          r_asm[IN_WIDTH-1:0] <= fifoData;
          r_asmMask[0]        <= 1'b1;
        end
      end else if (w_take) begin
        if (w_full) begin
          r_asmMask <= '0;
        end else begin
          for (int unsigned l = 0; l < LANES - 1; l++) begin
            if (r_cnt == CW'(l)) begin
              r_asm[l*IN_WIDTH +: IN_WIDTH] <= fifoData;
              r_asmMask[l]                  <= 1'b1;
            end
          end
        end
      end
    end
  end

  a_no_wrap: assert property (@(posedge rdclk) disable iff (rst)
    !(w_take && w_full && !w_out_free));

  word_out_reg #(
    .DW(IN_WIDTH * LANES),
    .MW(LANES)
  ) u_out (
    .i_clk   (rdclk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_mask  (w_load_mask),
    .i_take  (wordValid),
    .o_ready (wordReady),
    .o_data  (wordData),
    .o_mask  (wordMask),
    .o_free  (w_out_free)
  );

  assign flushPending = r_flushPending;

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

  localparam int unsigned W = 8;
  localparam int unsigned L = 4;

  logic           rdclk = 1'b0;
  logic           rst = 1'b1;
  logic           fifoReady = 1'b0;
  logic           fifoValid;
  logic [W-1:0]   fifoData = '0;
  logic           flush = 1'b0;
  logic           wordReady;
  logic           wordValid = 1'b0;
  logic [W*L-1:0] wordData;
  logic [L-1:0]   wordMask;
  logic           flushPending;

  always #5 rdclk = ~rdclk;

  byte_word_packer #(
    .IN_WIDTH(W),
    .LANES(L)
  ) dut (
    .rdclk        (rdclk),
    .rst          (rst),
    .fifoReady    (fifoReady),
    .fifoValid    (fifoValid),
    .fifoData     (fifoData),
    .flush        (flush),
    .wordReady    (wordReady),
    .wordValid    (wordValid),
    .wordData     (wordData),
    .wordMask     (wordMask),
    .flushPending (flushPending)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: bytes collected so far, pending flush, output register.
  logic [W-1:0]   q[$];
  logic           m_pend = 1'b0;
  logic           m_ov = 1'b0;
  logic [W*L-1:0] m_data = '0;
  logic [L-1:0]   m_mask = '0;

  // Values sampled from the DUT in the current cycle.
  logic           s_fv, s_wr, s_fp;
  logic [W*L-1:0] s_data;
  logic [L-1:0]   s_mask;

  // Words the DUT handed downstream, {mask, data}.
  logic [L+W*L-1:0] log_w[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [L+W*L-1:0] logged(input int unsigned idx);
    if (idx < log_w.size()) return log_w[idx];
    return 'x;
  endfunction

  task automatic model_pack();
    m_data = '0;
    for (int unsigned i = 0; i < q.size(); i++) m_data[i*W +: W] = q[i];
    m_mask = L'((1 << q.size()) - 1);
    m_ov = 1'b1;
    q.delete();
  endtask

  task automatic step(input logic r, input logic fr, input logic [W-1:0] fd,
                      input logic fl, input logic wv);
    logic m_fv, out_free, take, emit;
    @(negedge rdclk);
    rst = r; fifoReady = fr; fifoData = fd; flush = fl; wordValid = wv;
    #1;
    out_free = !m_ov || wv;
    m_fv = !r && !(q.size() == L - 1 && !out_free)
              && !(m_pend && q.size() != 0 && !out_free);
    s_fv = fifoValid; s_wr = wordReady; s_fp = flushPending;
    s_data = wordData; s_mask = wordMask;
    chk("fifoValid", 64'(s_fv), 64'(m_fv));
    chk("wordReady", 64'(s_wr), 64'(m_ov));
    chk("flushPending", 64'(s_fp), 64'(m_pend));
    chk("wordData", 64'(s_data), 64'(m_data));
    chk("wordMask", 64'(s_mask), 64'(m_mask));
    if (!r && s_wr && wv) log_w.push_back({s_mask, s_data});
    @(posedge rdclk);
    if (r) begin
      q.delete(); m_pend = 1'b0; m_ov = 1'b0; m_data = '0; m_mask = '0;
    end else begin
      take = fr && m_fv;
      emit = m_pend && q.size() != 0 && out_free;
      if (m_ov && wv) m_ov = 1'b0;
      if (emit) begin
        model_pack();
        m_pend = 1'b0;
      end
      if (take) q.push_back(fd);
      if (q.size() == L) model_pack();
      if (fl && q.size() != 0) m_pend = 1'b1;
      if (q.size() == 0) m_pend = 1'b0;
    end
  endtask

  task automatic bytes_in(input logic [W-1:0] b, input logic fl, input logic wv);
    step(1'b0, 1'b1, b, fl, wv);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    // 1. reset then idle
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("t1_fv_in_reset", 64'(s_fv), 64'd0);
    chk("t1_wr_in_reset", 64'(s_wr), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("t1_fv_after_reset", 64'(s_fv), 64'd1);
    chk("t1_data_after_reset", 64'(s_data), 64'd0);

    // 2. streaming with no backpressure
    log_w.delete();
    for (int unsigned i = 1; i <= 8; i++) bytes_in(W'(i * 8'h11), 1'b0, 1'b1);
    idle(2);
    chk("t2_word0", 64'(logged(0)), 64'h0F_4433_2211);
    chk("t2_word1", 64'(logged(1)), 64'h0F_8877_6655);

    // 3. backpressure with a full assembly
    log_w.delete();
    for (int unsigned i = 1; i <= 4; i++) bytes_in(W'(i * 8'h11), 1'b0, 1'b0);
    bytes_in(8'hAA, 1'b0, 1'b0);
    bytes_in(8'hBB, 1'b0, 1'b0);
    bytes_in(8'hCC, 1'b0, 1'b0);
    bytes_in(8'hDD, 1'b0, 1'b0);
    chk("t3_fv_blocked", 64'(s_fv), 64'd0);
    chk("t3_data_held", 64'(s_data), 64'h4433_2211);
    bytes_in(8'hDD, 1'b0, 1'b0);
    bytes_in(8'hDD, 1'b0, 1'b1);
    chk("t3_fv_release", 64'(s_fv), 64'd1);
    idle(2);
    chk("t3_word0", 64'(logged(0)), 64'h0F_4433_2211);
    chk("t3_word1", 64'(logged(1)), 64'h0F_DDCC_BBAA);

    // 4. flush a partial word
    log_w.delete();
    bytes_in(8'h01, 1'b0, 1'b1);
    bytes_in(8'h02, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(1);
    chk("t4_pending", 64'(s_fp), 64'd1);
    idle(1);
    chk("t4_pend_clear", 64'(s_fp), 64'd0);
    chk("t4_partial", 64'({s_wr, s_mask, s_data}), 64'h13_0000_0201);
    bytes_in(8'h55, 1'b0, 1'b1);
    bytes_in(8'h66, 1'b1, 1'b1);
    idle(3);
    chk("t4_next_lane0", 64'(logged(1)), 64'h03_0000_6655);

    // 5. flush with a same-cycle byte, with a completing byte, at cnt 0
    log_w.delete();
    bytes_in(8'h01, 1'b0, 1'b1);
    bytes_in(8'h02, 1'b0, 1'b1);
    bytes_in(8'h03, 1'b1, 1'b1);
    idle(3);
    chk("t5_with_byte", 64'(logged(0)), 64'h07_0003_0201);
    log_w.delete();
    bytes_in(8'h10, 1'b0, 1'b1);
    bytes_in(8'h20, 1'b0, 1'b1);
    bytes_in(8'h30, 1'b0, 1'b1);
    bytes_in(8'h40, 1'b1, 1'b1);
    idle(3);
    chk("t5_full_count", 64'(log_w.size()), 64'd1);
    chk("t5_full_word", 64'(logged(0)), 64'h0F_4030_2010);
    log_w.delete();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(3);
    chk("t5_cnt0_count", 64'(log_w.size()), 64'd0);

    // 6. reset mid-word
    log_w.delete();
    bytes_in(8'h01, 1'b0, 1'b1);
    bytes_in(8'h02, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    chk("t6_fv_in_reset", 64'(s_fv), 64'd0);
    for (int unsigned i = 0; i < 4; i++) bytes_in(W'(8'h10 + i), 1'b0, 1'b1);
    idle(2);
    chk("t6_count", 64'(log_w.size()), 64'd1);
    chk("t6_word", 64'(logged(0)), 64'h0F_1312_1110);

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           W'($urandom),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
